pc_select_reg: RTL and testbench

PC_SELECT_REG -- requirements
Module: pc_select_reg

---
 rtl/pc_select_reg_if.sv | 39 +++
 rtl/pc_select_reg.sv | 84 ++++++++
 tb/tb_pc_select_reg.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_select_reg_if.sv
// Fetch-address select bundle: redirect, stall and halt inputs
// plus the fetch PC, flush, status and counter outputs.
//
// Ports (grouped signals):
//   PCWrite, EX_BranchTaken, EX_BranchPC, ID_Jump, ID_JumpPC,
//   ID_Halt                         -> into the PC selector
//   IF_PC, IF_PCadd4, IF_ID_Flush, ID_EX_Flush, Halted, PC_Err,
//   RedirectCnt                     <- from the PC selector
interface pc_select_reg_if #(
    parameter int CNT_W = 16
);
    logic             PCWrite;
    logic             EX_BranchTaken;
    logic [31:0]      EX_BranchPC;
    logic             ID_Jump;
    logic [31:0]      ID_JumpPC;
    logic             ID_Halt;
    logic [31:0]      IF_PC;
    logic [31:0]      IF_PCadd4;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             Halted;
    logic             PC_Err;
    logic [CNT_W-1:0] RedirectCnt;

    modport master (
        output PCWrite, EX_BranchTaken, EX_BranchPC,
        output ID_Jump, ID_JumpPC, ID_Halt,
        input  IF_PC, IF_PCadd4, IF_ID_Flush, ID_EX_Flush,
        input  Halted, PC_Err, RedirectCnt
    );

    modport slave (
        input  PCWrite, EX_BranchTaken, EX_BranchPC,
        input  ID_Jump, ID_JumpPC, ID_Halt,
        output IF_PC, IF_PCadd4, IF_ID_Flush, ID_EX_Flush,
        output Halted, PC_Err, RedirectCnt
    );
endinterface

// File: rtl/pc_select_reg.sv
// Fetch PC register with branch/jump redirect, stall, halt,
// misaligned-target flag and saturating redirect counter.
//
// Ports:
//   CLK    - rising-edge clock
//   Reset  - asynchronous active-low reset
//   bus    - pc_select_reg_if.slave (inputs and outputs above)
module pc_select_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic            CLK,
    input  logic            Reset,
    pc_select_reg_if.slave  bus
);

    typedef enum logic {RUN, HALT} state_t;

    state_t           state;
    logic [31:0]      pc;
    logic [31:0]      pc_add4;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] cnt;

    logic             run;
    logic             take_br;
    logic             take_jmp;
    logic             go_halt;
    logic             redirect;
    logic [31:0]      tgt;

    assign run     = (state == RUN);
    assign pc_add4 = pc + 32'd4;

    // A taken branch wins over everything: the instruction in ID
    // (stalled, jumping or halting) is on the wrong path.
    // Halt and jump both need a live ID slot; halt wins if both.
    assign take_br  = run & bus.EX_BranchTaken;
    assign go_halt  = run & ~bus.EX_BranchTaken & bus.PCWrite
                    & bus.ID_Halt;
    assign take_jmp = run & ~bus.EX_BranchTaken & bus.PCWrite
                    & bus.ID_Jump & ~bus.ID_Halt;
    assign redirect = take_br | take_jmp;
    assign tgt      = take_br ? bus.EX_BranchPC : bus.ID_JumpPC;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state  <= RUN;
            pc     <= RESET_PC;
            halted <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
        end else if (run) begin
            if (redirect) begin
                // Misaligned targets are word-aligned and flagged.
                pc <= {tgt[31:2], 2'b00};
                if (tgt[1:0] != 2'b00)
                    err <= 1'b1;
                if (cnt != '1)
                    cnt <= cnt + CNT_W'(1);
            end else if (go_halt) begin
                pc     <= pc_add4;
                state  <= HALT;
                halted <= 1'b1;
            end else if (bus.PCWrite) begin
                pc <= pc_add4;
            end
        end
    end

    // Flushes are combinational; Reset gating keeps them low while
    // the async reset is held even if a branch input is active.
    assign bus.IF_ID_Flush = Reset & run
        & (bus.EX_BranchTaken | (bus.ID_Jump & bus.PCWrite));
    assign bus.ID_EX_Flush = Reset & run & bus.EX_BranchTaken;

    assign bus.IF_PC       = pc;
    assign bus.IF_PCadd4   = pc_add4;
    assign bus.Halted      = halted;
    assign bus.PC_Err      = err;
    assign bus.RedirectCnt = cnt;

endmodule

// File: tb/tb_pc_select_reg.sv
// Self-checking bench for pc_select_reg: directed vector table,
// hand sequences for reset/wrap/saturation, randomized model check.
module tb_pc_select_reg;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic CLK;
    logic Reset;
    int   n_chk;
    int   n_fail;

    pc_select_reg_if #(.CNT_W(CNT_W)) bus ();

    pc_select_reg #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          pw;
        bit          br;
        logic [31:0] bpc;
        bit          jmp;
        logic [31:0] jpc;
        bit          hlt;
        bit          fi;
        bit          fe;
        logic [31:0] pc;
        bit          hd;
        bit          er;
        int          cnt;
    } vec_t;

    vec_t tbl[15];

    // reference model state
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_err;
    int          m_cnt;

    function automatic vec_t mk(
        input bit pw, input bit br, input logic [31:0] bpc,
        input bit jmp, input logic [31:0] jpc, input bit hlt,
        input bit fi, input bit fe, input logic [31:0] pc,
        input bit hd, input bit er, input int cnt);
        vec_t v;
        v.pw = pw; v.br = br; v.bpc = bpc;
        v.jmp = jmp; v.jpc = jpc; v.hlt = hlt;
        v.fi = fi; v.fe = fe; v.pc = pc;
        v.hd = hd; v.er = er; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit pw, input bit br,
                         input logic [31:0] bpc, input bit jmp,
                         input logic [31:0] jpc, input bit hlt);
        bus.PCWrite        = pw;
        bus.EX_BranchTaken = br;
        bus.EX_BranchPC    = bpc;
        bus.ID_Jump        = jmp;
        bus.ID_JumpPC      = jpc;
        bus.ID_Halt        = hlt;
    endtask

    task automatic chk_regs(input string tag,
                            input logic [31:0] pc, input bit hd,
                            input bit er, input int cnt);
        chk({tag, " IF_PC"}, bus.IF_PC, pc);
        chk({tag, " Halted"}, 32'(bus.Halted), 32'(hd));
        chk({tag, " PC_Err"}, 32'(bus.PC_Err), 32'(er));
        chk({tag, " RedirectCnt"}, 32'(bus.RedirectCnt), cnt);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b0;
        drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        #1;
        chk("rst IF_ID_Flush", 32'(bus.IF_ID_Flush), 32'd0);
        chk("rst ID_EX_Flush", 32'(bus.ID_EX_Flush), 32'd0);
        chk_regs("rst", 32'h0, 1'b0, 1'b0, 0);
        @(posedge CLK);
        #1;
        chk("rst held IF_PC", bus.IF_PC, 32'h0);
        Reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        m_pc = 32'h0; m_halt = 0; m_err = 0; m_cnt = 0;
    endtask

    // Model step: rules stated directly in terms of pipeline intent.
    task automatic model_step(input bit pw, input bit br,
                              input logic [31:0] bpc, input bit jmp,
                              input logic [31:0] jpc, input bit hlt);
        logic [31:0] t;
        bit          redir;
        redir = 0;
        t = 32'h0;
        if (m_halt) return;
        if (br) begin
            redir = 1; t = bpc;
        end else if (!pw) begin
            return;
        end else if (hlt) begin
            m_pc = m_pc + 32'd4; m_halt = 1;
        end else if (jmp) begin
            redir = 1; t = jpc;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            m_pc = t - (t % 4);
            if (t % 4 != 0) m_err = 1;
            if (m_cnt < CMAX) m_cnt++;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        Reset  = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        tbl[0]  = mk(1,0,32'h0,0,32'h0,0, 0,0,32'h4,0,0,0);
        tbl[1]  = mk(1,0,32'h0,0,32'h0,0, 0,0,32'h8,0,0,0);
        tbl[2]  = mk(1,0,32'h0,0,32'h0,0, 0,0,32'hC,0,0,0);
        tbl[3]  = mk(1,1,32'h84,0,32'h0,0, 1,1,32'h84,0,0,1);
        tbl[4]  = mk(0,1,32'h7C,0,32'h0,0, 1,1,32'h7C,0,0,2);
        tbl[5]  = mk(1,1,32'h20,0,32'h0,0, 1,1,32'h20,0,0,3);
        tbl[6]  = mk(0,0,32'h0,1,32'h100,0, 0,0,32'h20,0,0,3);
        tbl[7]  = mk(1,0,32'h0,1,32'h100,0, 1,0,32'h100,0,0,4);
        tbl[8]  = mk(1,1,32'h32,0,32'h0,0, 1,1,32'h30,0,1,5);
        tbl[9]  = mk(1,0,32'h0,0,32'h0,0, 0,0,32'h34,0,1,5);
        tbl[10] = mk(0,0,32'h0,0,32'h0,0, 0,0,32'h34,0,1,5);
        tbl[11] = mk(1,1,32'h40,0,32'h0,1, 1,1,32'h40,0,1,6);
        tbl[12] = mk(1,0,32'h0,0,32'h0,1, 0,0,32'h44,1,1,6);
        tbl[13] = mk(1,0,32'h0,1,32'h200,0, 0,0,32'h44,1,1,6);
        tbl[14] = mk(1,1,32'h300,0,32'h0,0, 0,0,32'h44,1,1,6);

        do_reset();

        // directed table
        for (int i = 0; i < 15; i++) begin
            logic [31:0] prev;
            string       tag;
            tag  = $sformatf("vec%0d", i);
            prev = (i == 0) ? 32'h0 : tbl[i-1].pc;
            @(negedge CLK);
            drive(tbl[i].pw, tbl[i].br, tbl[i].bpc,
                  tbl[i].jmp, tbl[i].jpc, tbl[i].hlt);
            #1;
            chk({tag, " IF_PCadd4"}, bus.IF_PCadd4, prev + 32'd4);
            chk({tag, " IF_ID_Flush"}, 32'(bus.IF_ID_Flush),
                32'(tbl[i].fi));
            chk({tag, " ID_EX_Flush"}, 32'(bus.ID_EX_Flush),
                32'(tbl[i].fe));
            @(posedge CLK);
            #1;
            chk_regs(tag, tbl[i].pc, tbl[i].hd, tbl[i].er,
                     tbl[i].cnt);
        end

        // async reset pulse between edges while halted
        @(negedge CLK);
        #2;
        Reset = 1'b0;
        #1;
        chk_regs("halt rst", 32'h0, 1'b0, 1'b0, 0);
        #1;
        Reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge CLK);
        #1;
        chk("post rst IF_PC", bus.IF_PC, 32'h4);

        // wrap at top of address space
        @(negedge CLK);
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        @(posedge CLK);
        #1;
        chk("wrap IF_PC", bus.IF_PC, 32'hFFFF_FFFC);
        chk("wrap IF_PCadd4", bus.IF_PCadd4, 32'h0);
        @(negedge CLK);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge CLK);
        #1;
        chk("wrap next IF_PC", bus.IF_PC, 32'h0);

        // counter saturation
        for (int i = 0; i < CMAX + 5; i++) begin
            @(negedge CLK);
            drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        end
        @(posedge CLK);
        #1;
        chk("sat RedirectCnt", 32'(bus.RedirectCnt), CMAX);
        chk("sat PC_Err", 32'(bus.PC_Err), 32'd0);

        // randomized run against the model
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                bit          pw, br, jmp, hlt;
                logic [31:0] bpc, jpc;
                pw  = ($urandom_range(0, 3) != 0);
                br  = ($urandom_range(0, 4) == 0);
                jmp = ($urandom_range(0, 3) == 0);
                hlt = ($urandom_range(0, 79) == 0);
                bpc = $urandom;
                jpc = $urandom;
                @(negedge CLK);
                drive(pw, br, bpc, jmp, jpc, hlt);
                #1;
                chk("rnd IF_PCadd4", bus.IF_PCadd4, m_pc + 32'd4);
                chk("rnd IF_ID_Flush", 32'(bus.IF_ID_Flush),
                    32'(!m_halt && (br || (jmp && pw))));
                chk("rnd ID_EX_Flush", 32'(bus.ID_EX_Flush),
                    32'(!m_halt && br));
                model_step(pw, br, bpc, jmp, jpc, hlt);
                @(posedge CLK);
                #1;
                chk_regs("rnd", m_pc, m_halt, m_err, m_cnt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
